// File: rtl/order_msg_packer.sv
// rtl/order_msg_packer.sv - packs 40-byte feed messages into 320-bit records and queues supported ones
module order_msg_packer #(
    parameter int MSG_BYTES  = 40,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             s_data,
    input  logic                   s_valid,
    input  logic                   s_last,
    output logic                   s_ready,
    output logic [8*MSG_BYTES-1:0] ff_buffer,
    output logic                   buffer_not_empty,
    input  logic                   buffer_pop,
    output logic                   fifo_full,
    output logic [CNT_W-1:0]       msg_count,
    output logic [CNT_W-1:0]       drop_count,
    output logic                   err_pulse
);

    localparam int REC_W = 8 * MSG_BYTES;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int IDX_W = $clog2(MSG_BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_BYTES - 1);
    localparam logic [PTR_W:0]   DEPTH_C  = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, COLLECT, DISCARD, PUSH} state_t;

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic [REC_W-1:0]   asm_rec;
    logic [REC_W-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W:0]     count;
    logic [PTR_W:0]     count_nxt;
    logic               accept;
    logic               type_ok;
    logic               do_pop;
    logic               space;
    logic               do_push;
    logic               drop;

    always_comb begin
        accept  = s_valid && s_ready;
        type_ok = asm_rec[REC_W-1 -: 8] inside {8'h53, 8'h44, 8'h45};
        do_pop  = buffer_pop && (count != '0);
        // a pop in the same cycle frees the slot the pending record needs
        space   = (count < DEPTH_C) || do_pop;
        do_push = (state == PUSH) && type_ok && space;
        drop    = 1'b0;
        case (state)
            IDLE:    drop = accept && s_last;
            COLLECT: drop = accept && ((s_last && idx != LAST_IDX) || (!s_last && idx == LAST_IDX));
            PUSH:    drop = !type_ok;
            default: drop = 1'b0;
        endcase
        count_nxt = count;
        if (do_push && !do_pop)
            count_nxt = count + 1'b1;
        else if (!do_push && do_pop)
            count_nxt = count - 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= '0;
            asm_rec    <= '0;
            s_ready    <= 1'b0;
            err_pulse  <= 1'b0;
            msg_count  <= '0;
            drop_count <= '0;
        end else begin
            s_ready   <= 1'b1;
            err_pulse <= drop;
            if (drop && !(&drop_count))
                drop_count <= drop_count + 1'b1;
            if (do_push && !(&msg_count))
                msg_count <= msg_count + 1'b1;
            case (state)
                IDLE: begin
                    if (accept) begin
                        asm_rec[REC_W-1 -: 8] <= s_data;
                        if (!s_last) begin
                            idx   <= IDX_W'(1);
                            state <= COLLECT;
                        end
                    end
                end
                COLLECT: begin
                    if (accept) begin
                        asm_rec[REC_W-1-8*int'(idx) -: 8] <= s_data;
                        idx <= idx + 1'b1;
                        if (s_last && idx == LAST_IDX) begin
                            state   <= PUSH;
                            s_ready <= 1'b0;
                        end else if (s_last) begin
                            state <= IDLE;
                        end else if (idx == LAST_IDX) begin
                            state <= DISCARD;
                        end
                    end
                end
                DISCARD: begin
                    if (accept && s_last)
                        state <= IDLE;
                end
                PUSH: begin
                    if (!type_ok || space)
                        state <= IDLE;
                    else
                        s_ready <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            count            <= '0;
            buffer_not_empty <= 1'b0;
            fifo_full        <= 1'b0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            count            <= count_nxt;
            buffer_not_empty <= (count_nxt != '0);
            fifo_full        <= (count_nxt == DEPTH_C);
        end
    end

    // record storage carries no reset; contents are meaningless while count is 0
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= asm_rec;
    end

    assign ff_buffer = mem[rd_ptr];

endmodule

// File: tb/tb_order_msg_packer.sv
// tb/tb_order_msg_packer.sv - directed self-checking bench for order_msg_packer
module tb_order_msg_packer;

    logic         clk = 1'b0;
    logic         reset;
    logic [7:0]   s_data;
    logic         s_valid;
    logic         s_last;
    logic         s_ready;
    logic [319:0] ff_buffer;
    logic         buffer_not_empty;
    logic         buffer_pop;
    logic         fifo_full;
    logic [15:0]  msg_count;
    logic [15:0]  drop_count;
    logic         err_pulse;

    int n_cmp = 0;
    int n_fail = 0;
    int stalls = 0;

    logic [319:0] r1, r2, r3, r6, r7;
    logic [319:0] r4 [5];
    logic [319:0] q [8];

    always #5 clk = ~clk;

    order_msg_packer #(.MSG_BYTES(40), .FIFO_DEPTH(4), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .ff_buffer(ff_buffer), .buffer_not_empty(buffer_not_empty), .buffer_pop(buffer_pop),
        .fifo_full(fifo_full), .msg_count(msg_count), .drop_count(drop_count), .err_pulse(err_pulse)
    );

    task automatic check(input string tag, input logic [319:0] got, input logic [319:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last);
        int guard = 0;
        s_data = d; s_valid = 1'b1; s_last = last;
        while (!s_ready && guard < 200) begin
            @(negedge clk);
            guard++;
            stalls++;
        end
        if (!s_ready) check("s_ready_wait", 320'(s_ready), 320'(1));
        @(negedge clk);
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic send_msg(input logic [319:0] rec, input int nbytes);
        for (int k = 0; k < nbytes; k++)
            send_byte((k < 40) ? rec[319-8*k -: 8] : 8'(k), k == nbytes - 1);
    endtask

    task automatic pop();
        buffer_pop = 1'b1;
        @(negedge clk);
        buffer_pop = 1'b0;
    endtask

    function automatic logic [319:0] make_rec(input logic [7:0] req, input logic [31:0] stock, input logic [7:0] seed);
        logic [319:0] r;
        for (int k = 0; k < 40; k++) r[319-8*k -: 8] = 8'(k) ^ seed;
        r[319:312] = req;
        r[183:152] = stock;
        return r;
    endfunction

    function automatic logic [7:0] type_of(input int i);
        case (i % 3)
            0:       return 8'h53;
            1:       return 8'h44;
            default: return 8'h45;
        endcase
    endfunction

    initial begin
        reset = 1'b1; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0; buffer_pop = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_s_ready", 320'(s_ready), 320'(0));
        check("rst_bne", 320'(buffer_not_empty), 320'(0));
        check("rst_full", 320'(fifo_full), 320'(0));
        check("rst_err", 320'(err_pulse), 320'(0));
        check("rst_msg", 320'(msg_count), 320'(0));
        check("rst_drop", 320'(drop_count), 320'(0));
        reset = 1'b0;
        check("rel_s_ready_low", 320'(s_ready), 320'(0));
        @(negedge clk);
        check("rel_s_ready_high", 320'(s_ready), 320'(1));

        // single add
        r1 = make_rec(8'h53, 32'h0000_0010, 8'h11);
        send_msg(r1, 40);
        check("t1_bne_early", 320'(buffer_not_empty), 320'(0));
        check("t1_rdy_push", 320'(s_ready), 320'(0));
        @(negedge clk);
        check("t1_bne", 320'(buffer_not_empty), 320'(1));
        check("t1_req", 320'(ff_buffer[319:312]), 320'(8'h53));
        check("t1_stock", 320'(ff_buffer[183:152]), 320'(32'h10));
        check("t1_rec", ff_buffer, r1);
        check("t1_msg", 320'(msg_count), 320'(1));
        check("t1_rdy", 320'(s_ready), 320'(1));
        pop();
        check("t1_empty", 320'(buffer_not_empty), 320'(0));

        // unsupported request type
        r2 = make_rec(8'h58, 32'h22, 8'h22);
        send_msg(r2, 40);
        check("t2_rdy_low", 320'(s_ready), 320'(0));
        check("t2_err_pre", 320'(err_pulse), 320'(0));
        @(negedge clk);
        check("t2_err", 320'(err_pulse), 320'(1));
        check("t2_rdy_back", 320'(s_ready), 320'(1));
        check("t2_drop", 320'(drop_count), 320'(1));
        check("t2_bne", 320'(buffer_not_empty), 320'(0));
        @(negedge clk);
        check("t2_err_off", 320'(err_pulse), 320'(0));
        check("t2_msg", 320'(msg_count), 320'(1));

        // short message then a good one
        send_msg(make_rec(8'h53, 32'h5, 8'h55), 21);
        check("t3_short_err", 320'(err_pulse), 320'(1));
        check("t3_short_drop", 320'(drop_count), 320'(2));
        r3 = make_rec(8'h44, 32'h0000_CAFE, 8'h33);
        send_msg(r3, 40);
        @(negedge clk);
        check("t3_rec", ff_buffer, r3);
        check("t3_msg", 320'(msg_count), 320'(2));
        pop();

        // long message: every byte accepted, one drop
        stalls = 0;
        send_msg(make_rec(8'h45, 32'h6, 8'h66), 45);
        check("t3_long_stalls", 320'(stalls), 320'(0));
        check("t3_long_drop", 320'(drop_count), 320'(2 + 1));
        check("t3_long_err_off", 320'(err_pulse), 320'(0));
        check("t3_long_bne", 320'(buffer_not_empty), 320'(0));
        check("t3_long_msg", 320'(msg_count), 320'(2));

        // fill the FIFO, fifth record waits for a pop
        for (int i = 0; i < 5; i++) r4[i] = make_rec(type_of(i), 32'h100 + 32'(i), 8'h40 + 8'(i));
        for (int i = 0; i < 4; i++) send_msg(r4[i], 40);
        @(negedge clk);
        check("t4_full", 320'(fifo_full), 320'(1));
        check("t4_msg4", 320'(msg_count), 320'(6));
        send_msg(r4[4], 40);
        repeat (3) @(negedge clk);
        check("t4_hold_rdy", 320'(s_ready), 320'(0));
        check("t4_hold_full", 320'(fifo_full), 320'(1));
        check("t4_hold_msg", 320'(msg_count), 320'(6));
        check("t4_head0", ff_buffer, r4[0]);
        pop();
        check("t4_still_full", 320'(fifo_full), 320'(1));
        check("t4_head1", ff_buffer, r4[1]);
        check("t4_msg5", 320'(msg_count), 320'(7));
        check("t4_rdy_back", 320'(s_ready), 320'(1));
        for (int i = 1; i < 5; i++) begin
            check($sformatf("t4_drain%0d", i), ff_buffer, r4[i]);
            pop();
        end
        check("t4_empty", 320'(buffer_not_empty), 320'(0));
        check("t4_not_full", 320'(fifo_full), 320'(0));

        // push and pop together at count 1, across pointer wrap
        for (int i = 0; i < 8; i++) q[i] = make_rec(type_of(i + 1), 32'h200 + 32'(i), 8'h80 + 8'(i));
        send_msg(q[0], 40);
        @(negedge clk);
        for (int i = 1; i < 8; i++) begin
            send_msg(q[i], 40);
            check($sformatf("t5_pre%0d", i), ff_buffer, q[i-1]);
            pop();
            check($sformatf("t5_bne%0d", i), 320'(buffer_not_empty), 320'(1));
            check($sformatf("t5_head%0d", i), ff_buffer, q[i]);
        end
        check("t5_not_full", 320'(fifo_full), 320'(0));
        pop();
        check("t5_empty", 320'(buffer_not_empty), 320'(0));
        check("t5_msg", 320'(msg_count), 320'(15));

        // asynchronous reset in the middle of a message
        r6 = make_rec(8'h53, 32'h66, 8'h99);
        send_msg(r6, 40);
        @(negedge clk);
        check("t6_pre_bne", 320'(buffer_not_empty), 320'(1));
        for (int k = 0; k < 17; k++) send_byte(r6[319-8*k -: 8], 1'b0);
        s_data = r6[319-8*17 -: 8]; s_valid = 1'b1;
        #2 reset = 1'b1;
        #1;
        check("t6_rst_rdy", 320'(s_ready), 320'(0));
        check("t6_rst_bne", 320'(buffer_not_empty), 320'(0));
        check("t6_rst_full", 320'(fifo_full), 320'(0));
        check("t6_rst_err", 320'(err_pulse), 320'(0));
        check("t6_rst_msg", 320'(msg_count), 320'(0));
        check("t6_rst_drop", 320'(drop_count), 320'(0));
        s_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        check("t6_rel_rdy_low", 320'(s_ready), 320'(0));
        @(negedge clk);
        check("t6_rel_rdy", 320'(s_ready), 320'(1));
        r7 = make_rec(8'h45, 32'h777, 8'h77);
        send_msg(r7, 40);
        @(negedge clk);
        check("t6_rec", ff_buffer, r7);
        check("t6_msg", 320'(msg_count), 320'(1));
        check("t6_drop", 320'(drop_count), 320'(0));
        check("t6_bne", 320'(buffer_not_empty), 320'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
